iram_1r1w1ck_param: RTL

Parametrised simple dual-port RAM with one write port, one read port and one clock. It generalises the fixed 64x85 instance to any width and depth and adds:
- a hardware initialisation sweep after reset;
- write-to-read bypass on address collision;
- a read-valid strobe;
- out-of-range address protection;
- an optional second output register stage.

It sits under the ICE datapath buffers wherever a BRAM-mapped array is needed.

---
 rtl/iram_pkg.sv | 22 ++
 rtl/iram_1r1w1ck_core.sv | 23 ++
 rtl/iram_1r1w1ck_param.sv | 126 ++++++++++++
 3 files changed

// File: rtl/iram_pkg.sv
// Shared types and constants for the iram_1r1w1ck_param RAM.
// Read latency follows the IRAM_OUT_REG_EN build option.
package iram_pkg;

   typedef logic [0:0] iram_state_t;
   localparam iram_state_t IRAM_INIT = 1'b0;
   localparam iram_state_t IRAM_RUN  = 1'b1;

   // Selects which source drives the read data once a read completes.
   typedef enum logic [1:0] {
      RD_SEL_ZERO = 2'd0,
      RD_SEL_BYP  = 2'd1,
      RD_SEL_MEM  = 2'd2
   } rd_sel_e;

`ifdef IRAM_OUT_REG_EN
   localparam int IRAM_RD_LAT = 2;
`else
   localparam int IRAM_RD_LAT = 1;
`endif

endpackage

// File: rtl/iram_1r1w1ck_core.sv
// Bare simple dual-port array with registered read; no reset so it maps onto block RAM.
module iram_1r1w1ck_core #(
   parameter int WIDTH = 85,
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/iram_1r1w1ck_param.sv
// Parametrised 1R1W single-clock RAM: init sweep, write-first bypass, range checks.
// Define IRAM_OUT_REG_EN for a second output register stage (read latency 2).
// Handshake: a write happens when ena & wea & init_done and addra is in range;
// a read is accepted when enb & init_done, and completes with a one-cycle dob_v pulse.
module iram_1r1w1ck_param
   import iram_pkg::*;
#(
   parameter int               WIDTH    = 85,
   parameter int               DEPTH    = 64,
   parameter int               AW       = $clog2(DEPTH),
   parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             ena,
   input  logic             wea,
   input  logic [AW-1:0]    addra,
   input  logic [WIDTH-1:0] dia,
   input  logic             enb,
   input  logic [AW-1:0]    addrb,
   output logic [WIDTH-1:0] dob,
   output logic             dob_v,
   output logic             init_done,
   output iram_state_t      fsm_state
);

   localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

   iram_state_t      state_q;
   logic [AW-1:0]    cnt_q;
   logic             in_init, wa_ok, rb_ok, wr_user, rd_acc, collide;
   logic             mem_we, mem_re;
   logic [AW-1:0]    mem_wa;
   logic [WIDTH-1:0] mem_wd, mem_rd, byp_q, rd_data;
   rd_sel_e          sel_q;
   logic             v1_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IRAM_INIT;
         cnt_q   <= '0;
      end else if (state_q == IRAM_INIT) begin
         cnt_q <= cnt_q + 1'b1;
         if (cnt_q == LAST) state_q <= IRAM_RUN;
      end
   end

   assign in_init   = (state_q == IRAM_INIT);
   assign init_done = ~in_init;
   assign fsm_state = state_q;

   assign wa_ok   = {1'b0, addra} < DEPTH_X;
   assign rb_ok   = {1'b0, addrb} < DEPTH_X;
   assign wr_user = init_done & ena & wea & wa_ok;
   assign rd_acc  = init_done & enb;
   assign collide = wr_user & rb_ok & (addra == addrb);

   // The sweep owns the write port until it finishes.
   assign mem_we = in_init | wr_user;
   assign mem_wa = in_init ? cnt_q : addra;
   assign mem_wd = in_init ? INIT_VAL : dia;
   assign mem_re = rd_acc & rb_ok;

   iram_1r1w1ck_core #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_core (
      .clk   (clk),
      .we    (mem_we),
      .waddr (mem_wa),
      .wdata (mem_wd),
      .re    (mem_re),
      .raddr (addrb),
      .rdata (mem_rd)
   );

   // Select and bypass data only move on an accepted read, so the mux output holds otherwise.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sel_q <= RD_SEL_ZERO;
         byp_q <= '0;
         v1_q  <= 1'b0;
      end else begin
         v1_q <= rd_acc;
         if (rd_acc) begin
            if (!rb_ok)       sel_q <= RD_SEL_ZERO;
            else if (collide) sel_q <= RD_SEL_BYP;
            else              sel_q <= RD_SEL_MEM;
         end
         if (rd_acc && collide) byp_q <= dia;
      end
   end

   always_comb begin
      rd_data = '0;
      case (sel_q)
         RD_SEL_BYP: rd_data = byp_q;
         RD_SEL_MEM: rd_data = mem_rd;
         default:    rd_data = '0;
      endcase
   end

`ifdef IRAM_OUT_REG_EN
   logic [WIDTH-1:0] dob2_q;
   logic             v2_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dob2_q <= '0;
         v2_q   <= 1'b0;
      end else begin
         v2_q <= v1_q;
         if (v1_q) dob2_q <= rd_data;
      end
   end

   assign dob   = dob2_q;
   assign dob_v = v2_q;
`else
   assign dob   = rd_data;
   assign dob_v = v1_q;
`endif

endmodule
